execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
- Parametrised multi-cycle multiply/divide execute unit. It sits beside the single-cycle ALU in the execute stage and handles the RV64M/RV32M operations, including the W (word) variants.
- It accepts one operation at a time over a valid/ready handshake and iterates one bit per cycle.
- It holds the result until the memory stage accepts it. The stall input from the memory stage maps onto out_ready.
- A pipeline flush aborts any in-flight operation.

Parameters:
- XLEN, 64: operand and result width. Must be even and at least 32.
- TAG_W, 5: width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  abort the in-flight operation and drop any held result
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept an operation
- in_func  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_word  in  1  word mode (MULW/DIVW/...)
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result (low = memory-stage stall)
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE, out_valid 0, out_result 0, out_tag 0, iteration counter 0. in_ready = 1 once reset deasserts.
- State machine has three states: IDLE, BUSY, DONE. in_ready = (state == IDLE) and not flush.
- Accept: in_valid & in_ready at a rising edge latches func, word, the operands, and the tag.
- Word mode (in_word = 1):
  - Operands are the low 32 bits, sign- or zero-extended as the func requires.
  - Iteration count n = 32; otherwise n = XLEN.
  - Result is bits [31:0] of the 32-bit result, sign-extended to XLEN.
  - in_word = 1 with func 1..3 executes as MULW.
- Special cases, detected at accept, go straight to DONE (out_valid high 1 cycle after the accept edge):
  - Divide by zero: DIV/DIVU quotient = all ones at the operating width; REM/REMU = dividend.
  - Signed overflow, most-negative / -1: DIV = dividend, REM = 0.
- Normal path:
  - BUSY runs exactly n cycles: shift-add multiply over a 2n-bit product, restoring divide on magnitudes with sign fix-up at the end.
  - Then DONE. out_valid rises exactly n+1 cycles after the accept edge.
- Result selection:
  - MUL: low n bits of the product.
  - MULH*: high n bits, with the signedness per func.
  - DIV*: quotient. REM*: remainder.
  - Remainder takes the sign of the dividend.
- DONE:
  - out_valid = 1. out_result and out_tag are stable while out_ready = 0, held indefinitely.
  - out_valid & out_ready at an edge moves to IDLE.
  - One bubble cycle is mandatory between results: no accept in the DONE→IDLE cycle.
- Flush:
  - At an edge with flush = 1, any state goes to IDLE and out_valid goes to 0.
  - An in_valid in the same cycle is not accepted.
  - Flush has priority over out_ready and over completion.
- Reset mid-operation: immediate return to the reset values; no partial result is ever presented.
- Inputs are ignored outside the accept cycle; operands may change while the unit is BUSY.

Test Plan:
- Reset, then MUL a=7 b=-3 (XLEN=64) → out_valid exactly 65 cycles after accept; result 0xFFFF_FFFF_FFFF_FFEB.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE; MULH a=-1 b=-1 → 0.
- DIV a=-7 b=2 → -3; REM → -1; DIVUW a=0x1_8000_0000 b=1 → 0xFFFF_FFFF_8000_0000, with out_valid 33 cycles after accept.
- DIV b=0 → all ones; REMU b=0 a=5 → 5; DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000. All three produce out_valid 1 cycle after accept.
- Hold out_ready = 0 for 10 cycles in DONE → result and tag stable, in_ready = 0. Then out_ready = 1 → IDLE, one bubble, next accept.
- Flush at cycle 20 of a DIV → out_valid never rises for that operation, in_ready = 1 next cycle. Async reset pulse mid-BUSY → all outputs at reset values immediately.

Source files
------------

// File: rtl/execute_muldiv.sv
// ---------------------------------------------------------------------------
// execute_muldiv
//   Multi-cycle RV64M/RV32M multiply/divide unit for the execute stage.
//   Accepts one operation at a time, iterates one bit per cycle (shift-add
//   multiply, restoring divide on magnitudes) and holds the result until the
//   memory stage takes it. Divide-by-zero and signed overflow finish after a
//   single cycle. flush aborts whatever is in flight.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   flush                 abort in-flight operation / drop held result
//   in_valid / in_ready   operation handshake
//   in_func, in_word      operation select (0..7) and word (W) mode
//   in_a, in_b, in_tag    operands and destination tag
//   out_valid / out_ready result handshake (out_ready low = stall)
//   out_result, out_tag   result and its tag
// ---------------------------------------------------------------------------
module execute_muldiv #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_func,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN + 1);
    localparam int PW = 2 * XLEN;
    localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W  = XLEN'($signed(32'h8000_0000));

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
        return ~v + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    state_e            state_q;
    logic [2:0]        func_q;
    logic              word_q;
    logic [TAG_W-1:0]  tag_q;
    logic [CW-1:0]     cnt_q;
    logic              special_q;
    logic [XLEN-1:0]   spec_q;
    logic              neg_a_q, neg_b_q;
    logic [PW-1:0]     acc_q, mcand_q;
    logic [XLEN-1:0]   mplier_q, dvd_q, dsr_q, rem_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_result_q;
    logic [TAG_W-1:0]  out_tag_q;

    // accept-time decode
    logic [2:0]        eff_func_s;
    logic              sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
    logic [XLEN-1:0]   ext_a_s, ext_b_s, mag_a_s, mag_b_s;
    logic              b_zero_s, ovf_s, special_s;
    logic [XLEN-1:0]   spec_val_s, dvd_init_s;
    logic [CW-1:0]     n_init_s;

    // per-iteration next state and final result
    logic [PW-1:0]     acc_d, mcand_d;
    logic [XLEN-1:0]   mplier_d, dvd_d, rem_d;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN-1:0]   rem_diff_s;
    logic              rem_ge_s;
    logic [PW-1:0]     prod_s;
    logic [XLEN-1:0]   quot_s, remv_s, raw_s, pick_s, result_s;

    assign in_ready   = (state_q == IDLE) && !flush;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

    // Decode the presented operation: signedness, magnitudes, special cases.
    always_comb begin
        // W-mode MULH/MULHSU/MULHU collapse onto MULW
        if (in_word && (in_func != 3'd0) && !in_func[2]) begin
            eff_func_s = 3'd0;
        end else begin
            eff_func_s = in_func;
        end
        case (eff_func_s)
            3'd0, 3'd1, 3'd4, 3'd6: begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
            3'd2:                   begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
            default:                begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
        endcase
        if (in_word) begin
            ext_a_s = sgn_a_s ? sext_w(in_a[31:0]) : XLEN'(in_a[31:0]);
            ext_b_s = sgn_b_s ? sext_w(in_b[31:0]) : XLEN'(in_b[31:0]);
        end else begin
            ext_a_s = in_a;
            ext_b_s = in_b;
        end
        neg_a_s  = sgn_a_s && ext_a_s[XLEN-1];
        neg_b_s  = sgn_b_s && ext_b_s[XLEN-1];
        mag_a_s  = neg_a_s ? neg_x(ext_a_s) : ext_a_s;
        mag_b_s  = neg_b_s ? neg_x(ext_b_s) : ext_b_s;
        b_zero_s = (ext_b_s == ZERO_X);
        ovf_s    = sgn_b_s && eff_func_s[2] && (ext_b_s == ONES_X)
                   && (ext_a_s == (in_word ? MIN_W : MIN_X));
        special_s = eff_func_s[2] && (b_zero_s || ovf_s);
        // func bit 1 separates REM* (6,7) from DIV* (4,5)
        if (b_zero_s) begin
            spec_val_s = eff_func_s[1] ? ext_a_s : ONES_X;
        end else if (ovf_s) begin
            spec_val_s = eff_func_s[1] ? ZERO_X : ext_a_s;
        end else begin
            spec_val_s = ZERO_X;
        end
        // left-align the dividend so the first n shifts consume it MSB first
        dvd_init_s = in_word ? (mag_a_s << (XLEN - 32)) : mag_a_s;
        n_init_s   = in_word ? CW'(32) : CW'(XLEN);
    end

    // One multiply or divide step plus the sign fix-up and result select.
    always_comb begin
        acc_d      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d    = {mcand_q[PW-2:0], 1'b0};
        mplier_d   = {1'b0, mplier_q[XLEN-1:1]};
        rem_sh_s   = {rem_q, dvd_q[XLEN-1]};
        rem_diff_s = rem_sh_s[XLEN-1:0] - dsr_q;
        rem_ge_s   = (rem_sh_s >= {1'b0, dsr_q});
        rem_d      = rem_ge_s ? rem_diff_s : rem_sh_s[XLEN-1:0];
        dvd_d      = {dvd_q[XLEN-2:0], rem_ge_s};
        prod_s     = (neg_a_q ^ neg_b_q) ? neg_p(acc_q) : acc_q;
        quot_s     = (neg_a_q ^ neg_b_q) ? neg_x(dvd_q) : dvd_q;
        remv_s     = neg_a_q ? neg_x(rem_q) : rem_q;
        case (func_q)
            3'd0:             raw_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: raw_s = prod_s[PW-1:XLEN];
            3'd4, 3'd5:       raw_s = quot_s;
            default:          raw_s = remv_s;
        endcase
        pick_s   = special_q ? spec_q : raw_s;
        result_s = word_q ? sext_w(pick_s[31:0]) : pick_s;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            func_q       <= 3'd0;
            word_q       <= 1'b0;
            tag_q        <= {TAG_W{1'b0}};
            cnt_q        <= {CW{1'b0}};
            special_q    <= 1'b0;
            spec_q       <= ZERO_X;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            acc_q        <= {PW{1'b0}};
            mcand_q      <= {PW{1'b0}};
            mplier_q     <= ZERO_X;
            dvd_q        <= ZERO_X;
            dsr_q        <= ZERO_X;
            rem_q        <= ZERO_X;
            out_valid_q  <= 1'b0;
            out_result_q <= ZERO_X;
            out_tag_q    <= {TAG_W{1'b0}};
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q   <= BUSY;
                        func_q    <= eff_func_s;
                        word_q    <= in_word;
                        tag_q     <= in_tag;
                        special_q <= special_s;
                        spec_q    <= spec_val_s;
                        // special cases skip iteration and finalise next edge
                        cnt_q     <= special_s ? {CW{1'b0}} : n_init_s;
                        neg_a_q   <= neg_a_s;
                        neg_b_q   <= neg_b_s;
                        acc_q     <= {PW{1'b0}};
                        mcand_q   <= PW'(mag_a_s);
                        mplier_q  <= mag_b_s;
                        dvd_q     <= dvd_init_s;
                        dsr_q     <= mag_b_s;
                        rem_q     <= ZERO_X;
                    end
                end
                BUSY: begin
                    if (cnt_q != {CW{1'b0}}) begin
                        cnt_q <= cnt_q - CW'(1);
                        if (func_q[2]) begin
                            rem_q <= rem_d;
                            dvd_q <= dvd_d;
                        end else begin
                            acc_q    <= acc_d;
                            mcand_q  <= mcand_d;
                            mplier_q <= mplier_d;
                        end
                    end else begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= result_s;
                        out_tag_q    <= tag_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv (XLEN=64): directed cases, a
// random batch against an arithmetic reference, stall, flush and reset.
module tb_execute_muldiv;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_word;
    logic [2:0]  in_func;
    logic [63:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    always #5 clk = ~clk;

    execute_muldiv #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_word(in_word), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        int          lat;
    } sb_t;
    sb_t sb_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // Arithmetic reference built on the simulator's own * / %.
    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
        r = 64'd0; r32 = 32'd0;
        if (w) begin
            case (f)
                3'd4: if (b32 == 32'd0) r32 = 32'hFFFF_FFFF;
                      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
                      else r32 = sa32 / sb32;
                3'd5: r32 = (b32 == 32'd0) ? 32'hFFFF_FFFF : a32 / b32;
                3'd6: if (b32 == 32'd0) r32 = a32;
                      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 32'd0;
                      else r32 = sa32 % sb32;
                3'd7: r32 = (b32 == 32'd0) ? a32 : a32 % b32;
                default: r32 = a32 * b32;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            ea = {64'd0, a}; eb = {64'd0, b};
            if (f == 3'd1 || f == 3'd2) ea = {{64{a[63]}}, a};
            if (f == 3'd1) eb = {{64{b[63]}}, b};
            p = ea * eb;
            case (f)
                3'd0: r = p[63:0];
                3'd1, 3'd2, 3'd3: r = p[127:64];
                3'd4: if (b == 64'd0) r = {64{1'b1}};
                      else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r = a;
                      else r = sa / sb;
                3'd5: r = (b == 64'd0) ? {64{1'b1}} : a / b;
                3'd6: if (b == 64'd0) r = a;
                      else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r = 64'd0;
                      else r = sa % sb;
                default: r = (b == 64'd0) ? a : a % b;
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic bz, ovf;
        bz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                          : (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}));
        if (f[2] && (bz || ovf)) return 1;
        return w ? 33 : 65;
    endfunction

    // Issue one operation, wait (bounded) for its result and check it.
    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp_res, input int lat, input int hold);
        sb_t e, got_e;
        int  cyc;
        logic seen;
        @(negedge clk);
        check_val("in_ready_idle", {63'd0, in_ready}, 64'd1);
        out_ready = (hold == 0);
        in_valid = 1'b1; in_func = f; in_word = w; in_a = a; in_b = b; in_tag = tag;
        @(posedge clk); #1;
        e.res = exp_res; e.tag = tag; e.lat = lat;
        sb_q.push_back(e);
        in_valid = 1'b0;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        in_func = 3'($urandom_range(0, 7)); in_tag = 5'($urandom_range(0, 31));
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_val("done_seen", {63'd0, seen}, 64'd1);
        if (seen && sb_q.size() > 0) begin
            got_e = sb_q.pop_front();
            check_val("latency", 64'(cyc), 64'(got_e.lat));
            check_val("result", out_result, got_e.res);
            check_val("tag", {59'd0, out_tag}, {59'd0, got_e.tag});
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check_val("hold_valid", {63'd0, out_valid}, 64'd1);
                check_val("hold_result", out_result, got_e.res);
                check_val("hold_tag", {59'd0, out_tag}, {59'd0, got_e.tag});
                check_val("hold_in_ready", {63'd0, in_ready}, 64'd0);
            end
            if (hold > 0) begin
                @(negedge clk);
                out_ready = 1'b1;
            end
        end
        @(posedge clk); #1;
        check_val("after_valid", {63'd0, out_valid}, 64'd0);
        check_val("after_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [2:0]  rf;
        logic        rw;
        logic [63:0] ra, rb;
        int          highs;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_func = 3'd0; in_word = 1'b0;
        in_a = 64'd0; in_b = 64'd0; in_tag = 5'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_result", out_result, 64'd0);
        check_val("rst_tag", {59'd0, out_tag}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed arithmetic
        run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        run_op(3'd3, 1'b0, {64{1'b1}}, {64{1'b1}}, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run_op(3'd1, 1'b0, {64{1'b1}}, {64{1'b1}}, 5'd3, 64'd0, 65, 0);
        run_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, {64{1'b1}}, 65, 0);
        run_op(3'd5, 1'b1, 64'h1_8000_0000, 64'd1, 5'd6, 64'hFFFF_FFFF_8000_0000, 33, 0);
        // Special cases
        run_op(3'd4, 1'b0, 64'd123, 64'd0, 5'd7, {64{1'b1}}, 1, 0);
        run_op(3'd7, 1'b0, 64'd5, 64'd0, 5'd8, 64'd5, 1, 0);
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd9,
               64'h8000_0000_0000_0000, 1, 0);
        // Word MULH collapses to MULW; result held under a 10-cycle stall
        run_op(3'd1, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 33, 10);

        // Random operations against the reference
        for (int k = 0; k < 14; k++) begin
            rf = 3'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom} >> $urandom_range(0, 40);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            rb = {$urandom, $urandom} >> $urandom_range(0, 62);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_op(rf, rw, ra, rb, 5'(k + 11), ref_model(rf, rw, ra, rb),
                   exp_lat(rf, rw, ra, rb), 0);
        end

        // Flush during a DIV: no result, new op in the flush cycle ignored
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_func = 3'd4; in_word = 1'b0; in_a = 64'd100; in_b = 64'd7; in_tag = 5'd30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_func = 3'd0; in_a = 64'd3; in_b = 64'd3;
        @(posedge clk); #1;
        check_val("flush_valid", {63'd0, out_valid}, 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check_val("flush_in_ready", {63'd0, in_ready}, 64'd1);
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (out_valid) highs++;
        end
        check_val("flush_no_result", 64'(highs), 64'd0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; in_func = 3'd0; in_word = 1'b0; in_a = 64'd9; in_b = 64'd9; in_tag = 5'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("amid_valid", {63'd0, out_valid}, 64'd0);
        check_val("amid_result", out_result, 64'd0);
        check_val("amid_tag", {59'd0, out_tag}, 64'd0);
        #1;
        reset = 1'b0;
        #1;
        check_val("amid_in_ready", {63'd0, in_ready}, 64'd1);
        highs = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) highs++;
        end
        check_val("amid_no_result", 64'(highs), 64'd0);
        run_op(3'd0, 1'b0, 64'd3, 64'd4, 5'd21, 64'd12, 65, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
